mod_buzzer_seq: RTL and testbench

//  Parametrised beep-pattern generator driving a piezo pin: programmable tone pitch,

---
 rtl/mod_buzzer_seq.sv | 205 ++++++++++++++++++++
 tb/tb_mod_buzzer_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_buzzer_seq.sv
// Beep-pattern generator for a piezo pin: programmable pitch, tone length, gap and repeat count.
// Define BUZZER_SIM_FAST_EN to force the millisecond prescaler to 10 clocks for simulation.
module mod_buzzer_seq #(
  parameter int CLK_HZ = 4_000_000,
  parameter int HALF_W = 16,
  parameter int DUR_W  = 16,
  parameter int REP_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [HALF_W-1:0] half_per_i,
  input  logic [DUR_W-1:0]  dur_ms_i,
  input  logic [DUR_W-1:0]  gap_ms_i,
  input  logic [REP_W-1:0]  reps_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pin_o
);

`ifdef BUZZER_SIM_FAST_EN
  localparam int MS_DIV = 10;
`else
  localparam int MS_DIV = CLK_HZ / 1000;
`endif
  localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(MS_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;

  // Pattern fields captured at start; they stay fixed while the pattern runs.
  logic [HALF_W-1:0] half_q, half_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  gap_q, gap_d;

  logic [REP_W-1:0]  reps_rem_q, reps_rem_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DUR_W-1:0]  ms_rem_q, ms_rem_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;

  logic              pin_d, busy_d, done_d;

  logic              ms_tick;
  logic              phase_end;
  logic              half_end;
  logic [PRE_W-1:0]  pre_next;
  logic [DUR_W-1:0]  ms_rem_next;

  // A phase ends on the millisecond tick that consumes its last remaining ms.
  assign ms_tick     = (pre_cnt_q == PRE_LAST);
  assign phase_end   = ms_tick && (ms_rem_q == DUR_ONE);
  assign half_end    = (half_q != '0) && (half_cnt_q == (half_q - HALF_ONE));
  assign pre_next    = ms_tick ? '0 : (pre_cnt_q + PRE_ONE);
  assign ms_rem_next = ms_tick ? (ms_rem_q - DUR_ONE) : ms_rem_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first; any path that skipped one would infer a latch.
    state_d    = state_q;
    half_d     = half_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    reps_rem_d = reps_rem_q;
    pre_cnt_d  = pre_cnt_q;
    ms_rem_d   = ms_rem_q;
    half_cnt_d = half_cnt_q;
    pin_d      = pin_o;
    busy_d     = busy_o;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        pin_d  = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          half_d     = half_per_i;
          dur_d      = dur_ms_i;
          gap_d      = gap_ms_i;
          reps_rem_d = reps_i;
          pre_cnt_d  = '0;
          half_cnt_d = '0;
          ms_rem_d   = dur_ms_i;
          busy_d     = 1'b1;
          if ((dur_ms_i == '0) || (reps_i == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_TONE;
          end
        end
      end

      S_TONE: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else if (phase_end) begin
          pin_d      = 1'b0;
          reps_rem_d = reps_rem_q - REP_ONE;
          pre_cnt_d  = '0;
          half_cnt_d = '0;
          if (reps_rem_q == REP_ONE) begin
            state_d = S_DONE;
          end else if (gap_q == '0) begin
            ms_rem_d = dur_q;
          end else begin
            state_d  = S_GAP;
            ms_rem_d = gap_q;
          end
        end else begin
          pre_cnt_d = pre_next;
          ms_rem_d  = ms_rem_next;
          // A zero half period keeps the pin quiet but leaves the tone timing intact.
          if (half_q == '0) begin
            pin_d = 1'b0;
          end else if (half_end) begin
            half_cnt_d = '0;
            pin_d      = ~pin_o;
          end else begin
            half_cnt_d = half_cnt_q + HALF_ONE;
          end
        end
      end

      S_GAP: begin
        pin_d = 1'b0;
        if (abort_i) begin
          state_d = S_DONE;
        end else if (phase_end) begin
          state_d    = S_TONE;
          pre_cnt_d  = '0;
          half_cnt_d = '0;
          ms_rem_d   = dur_q;
        end else begin
          pre_cnt_d = pre_next;
          ms_rem_d  = ms_rem_next;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        pin_d      = 1'b0;
        busy_d     = 1'b0;
        pre_cnt_d  = '0;
        half_cnt_d = '0;
        ms_rem_d   = '0;
        reps_rem_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        pin_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Every way into DONE (normal end, abort, empty pattern) raises the single done pulse.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pin_d  = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the captured fields are ordinary flops, not a memory, so they are cleared too and never show X.
      state_q    <= S_IDLE;
      half_q     <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      reps_rem_q <= '0;
      pre_cnt_q  <= '0;
      ms_rem_q   <= '0;
      half_cnt_q <= '0;
      pin_o      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      reps_rem_q <= reps_rem_d;
      pre_cnt_q  <= pre_cnt_d;
      ms_rem_q   <= ms_rem_d;
      half_cnt_q <= half_cnt_d;
      pin_o      <= pin_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
    end
  end

endmodule

// File: tb/tb_mod_buzzer_seq.sv
// Self-checking bench for mod_buzzer_seq: directed patterns plus randomized ones, each compared
// cycle by cycle against an expected output trace built from the pattern rules.
module tb_mod_buzzer_seq;

  localparam int MS_DIV = 10;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] half_per_i = '0;
  logic [15:0] dur_ms_i = '0;
  logic [15:0] gap_ms_i = '0;
  logic [3:0]  reps_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, pin_o;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {pin, busy, done} after each edge, index 0 being the start edge.
  logic [2:0] exp_q[$];

  mod_buzzer_seq #(
    .CLK_HZ(10_000),
    .HALF_W(16),
    .DUR_W (16),
    .REP_W (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .half_per_i(half_per_i),
    .dur_ms_i  (dur_ms_i),
    .gap_ms_i  (gap_ms_i),
    .reps_i    (reps_i),
    .abort_i   (abort_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pin_o     (pin_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beep trace: entry edge, then per beep dur*MS_DIV tone edges (pin = floor(k/h) mod 2,
  // forced low on the last), then gap*MS_DIV silent edges between beeps, done pulse, idle.
  function automatic void build_model(input int h, input int d, input int g, input int r);
    exp_q.delete();
    if (d == 0 || r == 0) begin
      exp_q.push_back(3'b001);
    end else begin
      exp_q.push_back(3'b010);
      for (int b = 0; b < r; b++) begin
        for (int k = 1; k <= d * MS_DIV; k++) begin
          if (k < d * MS_DIV) begin
            logic p;
            p = (h != 0) && (((k / h) % 2) == 1);
            exp_q.push_back({p, 2'b10});
          end else if (b == r - 1) begin
            exp_q.push_back(3'b001);
          end else begin
            exp_q.push_back(3'b010);
          end
        end
        if (b < r - 1) begin
          for (int k = 1; k <= g * MS_DIV; k++) exp_q.push_back(3'b010);
        end
      end
    end
    exp_q.push_back(3'b000);
  endfunction

  // abort_at: edge index receiving abort (0 none, -1 random); reset_at: index before which reset hits (0 none).
  task automatic run_pattern(input string name, input int h, input int d, input int g, input int r,
                             input int abort_at, input int reset_at,
                             output int toggles, output int done_idx);
    int   ab;
    logic last_pin;
    logic [2:0] obs;
    build_model(h, d, g, r);
    ab = abort_at;
    if (ab < 0) ab = (exp_q.size() >= 3 && $urandom_range(0, 3) == 0) ?
                     int'($urandom_range(1, exp_q.size() - 2)) : 0;
    if (ab > 0) begin
      while (exp_q.size() > ab) void'(exp_q.pop_back());
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
    end
    toggles  = 0;
    done_idx = -1;
    last_pin = 1'b0;

    half_per_i = 16'(h);
    dur_ms_i   = 16'(d);
    gap_ms_i   = 16'(g);
    reps_i     = 4'(r);
    start_i    = 1'b1;
    abort_i    = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (reset_at > 0 && i == reset_at) begin
        #2 rst_n_i = 1'b0;
        #1 check($sformatf("%s_rst_async", name), {29'd0, pin_o, busy_o, done_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 check($sformatf("%s_rst_hold", name), {29'd0, pin_o, busy_o, done_o}, 32'd0);
        rst_n_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk_i);
          #1 check($sformatf("%s_post_rst[%0d]", name, j), {29'd0, pin_o, busy_o, done_o}, 32'd0);
          if (done_o) done_idx = i;
        end
        return;
      end
      @(posedge clk_i);
      #1;
      obs = {pin_o, busy_o, done_o};
      check($sformatf("%s[%0d]", name, i), {29'd0, obs}, {29'd0, exp_q[i]});
      if (pin_o !== last_pin) toggles++;
      last_pin = pin_o;
      if (done_o === 1'b1 && done_idx < 0) done_idx = i;
      // Scramble fields and fire stray starts: none of it may reach a running pattern.
      half_per_i = 16'($urandom_range(0, 7));
      dur_ms_i   = 16'($urandom_range(0, 7));
      gap_ms_i   = 16'($urandom_range(0, 7));
      reps_i     = 4'($urandom_range(0, 15));
      start_i    = (i < exp_q.size() - 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      abort_i    = (i + 1 == ab) ? 1'b1 :
                   ((i + 1 >= exp_q.size() - 1) ? ($urandom_range(0, 1) == 1) : 1'b0);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1 check($sformatf("%s_idle", name), {29'd0, pin_o, busy_o, done_o}, 32'd0);
    end
  endtask

  initial begin
    int tog, didx;

    // Outputs low while reset is held, even with start requested.
    start_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 check("rst_pin", {31'd0, pin_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b0;
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1 check($sformatf("idle_after_rst[%0d]", i), {29'd0, pin_o, busy_o, done_o}, 32'd0);
    end

    run_pattern("t2", 3, 2, 0, 1, 0, 0, tog, didx);
    check("t2_toggles", 32'(tog), 32'd6);
    check("t2_done_lat", 32'(didx), 32'd20);

    run_pattern("t3", 2, 1, 2, 3, 0, 0, tog, didx);
    check("t3_done_lat", 32'(didx), 32'd70);

    run_pattern("t4a", 2, 0, 1, 5, 0, 0, tog, didx);
    check("t4a_done_lat", 32'(didx), 32'd0);
    check("t4a_toggles", 32'(tog), 32'd0);
    run_pattern("t4b", 2, 4, 1, 0, 0, 0, tog, didx);
    check("t4b_done_lat", 32'(didx), 32'd0);

    run_pattern("t5", 2, 2, 0, 2, 7, 0, tog, didx);
    check("t5_done_lat", 32'(didx), 32'd7);

    run_pattern("t6", 2, 1, 2, 3, 0, 15, tog, didx);
    check("t6_no_done", 32'(didx), 32'hFFFF_FFFF);
    run_pattern("t6_after", 1, 1, 1, 2, 0, 0, tog, didx);
    check("t6_after_done_lat", 32'(didx), 32'd30);

    run_pattern("silent", 0, 2, 1, 2, 0, 0, tog, didx);
    check("silent_toggles", 32'(tog), 32'd0);

    for (int n = 0; n < 30; n++) begin
      run_pattern($sformatf("rnd%0d", n),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  -1, 0, tog, didx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
